// File: rtl/k_nns_unload_pkg.sv
// Shared definitions for the k-NN unload path: FSM encoding and the
// bit-width helper used for distance and index widths.
package k_nns_unload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // floor(log2(x))+1 for x >= 1: the number of bits needed to hold x
  function automatic int bits_for(input int x);
    int n;
    n = 0;
    for (int v = x; v > 0; v = v >> 1) n++;
    return n;
  endfunction

endpackage

// File: rtl/k_nns_unload_count.sv
// Population count of an N-bit word; the same COUNT block the k-NN core
// uses, so unload distances match the core's distance width exactly.
module k_nns_unload_count
  import k_nns_unload_pkg::*;
#(
  parameter int N  = 15,
  parameter int CW = bits_for(N)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/k_nns_unload.sv
// Snapshots the k-NN core result bus and query on start, then streams the
// K entries nearest-first with a recomputed Hamming distance per entry.
//
// Handshake: an entry moves when out_valid && out_ready at a rising edge;
// while out_valid && !out_ready every output holds its value; out_ready is
// ignored whenever out_valid is low.
module k_nns_unload
  import k_nns_unload_pkg::*;
#(
  parameter int W    = 15,
  parameter int K    = 4,
  parameter int LOGW = bits_for(W),
  parameter int LOGK = bits_for(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    g_input,
  input  logic [W*K-1:0]  knn_o,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_val,
  output logic [LOGW-1:0] out_dist,
  output logic [LOGK-1:0] out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  localparam logic [LOGK-1:0] LAST_IDX = LOGK'(K - 1);

  state_t          state;
  state_t          state_next;
  logic [W*K-1:0]  snap;
  logic [W-1:0]    query;
  logic [LOGK-1:0] idx;
  logic            xfer;
  logic            at_last;

  assign xfer    = (state == ST_SEND) && out_ready;
  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      snap  <= '0;
      query <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      // Capture only from IDLE so a stray start never disturbs an unload
      if (state == ST_IDLE && start) begin
        snap  <= knn_o;
        query <= g_input;
        idx   <= '0;
      end else if (xfer && !at_last) begin
        idx <= idx + LOGK'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_SEND;
      ST_SEND: if (xfer && at_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign out_valid = (state == ST_SEND);
  assign busy      = (state == ST_SEND);
  assign done      = (state == ST_DONE);
  assign out_idx   = idx;
  assign out_last  = out_valid && at_last;
  assign out_val   = snap[int'(idx)*W +: W];

  // Distance is recomputed against the captured query, never taken from the core
  k_nns_unload_count #(
    .N (W),
    .CW(LOGW)
  ) u_count (
    .bits (out_val ^ query),
    .count(out_dist)
  );

endmodule

// File: tb/tb_k_nns_unload.sv
// Bench for k_nns_unload: scenario tasks drive unloads, a scoreboard queue
// holds expected entries, and negedge monitors compare every transfer.
module tb_k_nns_unload;

  localparam int W  = 15;
  localparam int K  = 4;
  localparam int EW = W + 4 + 3 + 1;
  localparam int E1 = W + 4 + 1 + 1;

  localparam logic [W*K-1:0] SLOTS_A = {15'h7FFF, 15'h0007, 15'h0003, 15'h0001};
  localparam logic [W*K-1:0] SLOTS_B = {15'h1234, 15'h0F0F, 15'h7000, 15'h2AAA};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   g_input = '0;
  logic [W*K-1:0] knn_o = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_val;
  logic [3:0]     out_dist;
  logic [2:0]     out_idx;
  logic           out_last;
  logic           busy;
  logic           done;

  logic           start1 = 1'b0;
  logic [W-1:0]   g1 = '0;
  logic [W-1:0]   knn1 = '0;
  logic           valid1;
  logic           ready1 = 1'b0;
  logic [W-1:0]   val1;
  logic [3:0]     dist1;
  logic [0:0]     idx1;
  logic           last1;
  logic           busy1;
  logic           done1;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  logic [E1-1:0] exp1_q[$];

  always #5 clk = ~clk;

  k_nns_unload #(.W(W), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .g_input(g_input), .knn_o(knn_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_dist(out_dist), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  k_nns_unload #(.W(W), .K(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .g_input(g1), .knn_o(knn1),
    .out_valid(valid1), .out_ready(ready1), .out_val(val1),
    .out_dist(dist1), .out_idx(idx1), .out_last(last1),
    .busy(busy1), .done(done1)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected got=%h required=none", {out_val, out_dist, out_idx, out_last});
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_val, out_dist, out_idx, out_last} !== e) begin
          bad++;
          $display("FAIL xfer got=%h required=%h", {out_val, out_dist, out_idx, out_last}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid1 && ready1) begin
      total++;
      if (exp1_q.size() == 0) begin
        bad++;
        $display("FAIL xfer1_unexpected got=%h required=none", {val1, dist1, idx1, last1});
      end else begin
        logic [E1-1:0] e;
        e = exp1_q.pop_front();
        if ({val1, dist1, idx1, last1} !== e) begin
          bad++;
          $display("FAIL xfer1 got=%h required=%h", {val1, dist1, idx1, last1}, e);
        end
      end
    end
  end

  task automatic push_entries(input logic [W*K-1:0] slots, input logic [W-1:0] q);
    logic [W-1:0] v;
    for (int i = 0; i < K; i++) begin
      v = slots[i*W +: W];
      exp_q.push_back({v, 4'($countones(v ^ q)), 3'(i), 1'(i == K - 1)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, busy, done, out_last, out_idx, out_val} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0", {out_valid, busy, done, out_last, out_idx, out_val});
    end
    total++;
    if ({valid1, busy1, done1} !== 3'b000) begin
      bad++;
      $display("FAIL reset_k1 got=%b required=000", {valid1, busy1, done1});
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Always-ready unload: valid c1..c4, last only at c4, done only at c5
  task automatic test_unload(input logic [W*K-1:0] slots, input logic [W-1:0] q);
    knn_o = slots;
    g_input = q;
    out_ready = 1'b1;
    push_entries(slots, q);
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid, busy, done} !== {1'(c <= 4), 1'(c <= 4), 1'(c == 5)}) begin
        bad++;
        $display("FAIL unload_ctrl c%0d got=%b required=%b", c, {out_valid, busy, done},
                 {1'(c <= 4), 1'(c <= 4), 1'(c == 5)});
      end
      if (c <= 4) begin
        total++;
        if ({out_idx, out_last} !== {3'(c - 1), 1'(c == 4)}) begin
          bad++;
          $display("FAIL unload_idx c%0d got=%h required=%h", c, {out_idx, out_last}, {3'(c - 1), 1'(c == 4)});
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL unload_left got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    logic [W*K-1:0] s;
    logic [W-1:0]   ev;
    int             ei;
    s = SLOTS_A;
    knn_o = s;
    g_input = '0;
    out_ready = 1'b0;
    push_entries(s, '0);
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      out_ready = (c > 3);
      @(negedge clk);
      total++;
      if ({out_valid, done} !== {1'(c <= 7), 1'(c == 8)}) begin
        bad++;
        $display("FAIL stall_ctrl c%0d got=%b required=%b", c, {out_valid, done}, {1'(c <= 7), 1'(c == 8)});
      end
      if (c <= 7) begin
        ei = (c <= 4) ? 0 : c - 4;
        ev = s[ei*W +: W];
        total++;
        if ({out_val, out_idx} !== {ev, 3'(ei)}) begin
          bad++;
          $display("FAIL stall_hold c%0d got=%h required=%h", c, {out_val, out_idx}, {ev, 3'(ei)});
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_left got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_ignore_start();
    knn_o = SLOTS_A;
    g_input = '0;
    out_ready = 1'b1;
    push_entries(SLOTS_A, '0);
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1 start = (c == 2) || (c == 5);
      knn_o = (c >= 2) ? SLOTS_B : SLOTS_A;
      g_input = (c >= 2) ? 15'h7FFF : 15'h0000;
      @(negedge clk);
      total++;
      if ({out_valid, done} !== {1'(c <= 4), 1'(c == 5)}) begin
        bad++;
        $display("FAIL ignore_ctrl c%0d got=%b required=%b", c, {out_valid, done}, {1'(c <= 4), 1'(c == 5)});
      end
    end
    start = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL ignore_left got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    knn_o = SLOTS_B;
    g_input = 15'h0F0F;
    out_ready = 1'b1;
    push_entries(SLOTS_B, 15'h0F0F);
    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      rst = (c == 2);
      @(negedge clk);
      if (c >= 3) begin
        total++;
        if ({out_valid, busy, done} !== 3'b000) begin
          bad++;
          $display("FAIL midrst_ctrl c%0d got=%b required=000", c, {out_valid, busy, done});
        end
      end
      if (c == 3) begin
        total++;
        if ({out_val, out_idx} !== '0) begin
          bad++;
          $display("FAIL midrst_clear got=%h required=0", {out_val, out_idx});
        end
      end
    end
    total++;
    if (exp_q.size() != 3) begin
      bad++;
      $display("FAIL midrst_sent got=%0d left required=3", exp_q.size());
    end
    exp_q.delete();
    test_unload(SLOTS_B, 15'h0F0F);
  endtask

  task automatic test_k1();
    knn1 = 15'h5555;
    g1 = 15'h0000;
    ready1 = 1'b1;
    exp1_q.push_back({15'h5555, 4'd8, 1'b0, 1'b1});
    @(posedge clk);
    #1 start1 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      total++;
      if ({valid1, last1, done1} !== {1'(c == 1), 1'(c == 1), 1'(c == 2)}) begin
        bad++;
        $display("FAIL k1_ctrl c%0d got=%b required=%b", c, {valid1, last1, done1},
                 {1'(c == 1), 1'(c == 1), 1'(c == 2)});
      end
    end
    total++;
    if (exp1_q.size() != 0) begin
      bad++;
      $display("FAIL k1_left got=%0d required=0", exp1_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unload(SLOTS_A, 15'h0000);
    test_stall();
    test_ignore_start();
    test_mid_reset();
    test_unload('0, 15'h7FFF);
    test_unload(SLOTS_B, 15'h5A5A);
    test_k1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
